fl_fifo: RTL and testbench

- Synchronous FrameLink FIFO for the verification framework.
- Sits directly downstream of the FrameLink driver/sender: it accepts FrameLink words on RX and re-emits them unchanged on TX.
- TX feeds the FrameLink monitor/responder.
- Serves as the reference DUT for FL component benches and as a reusable elastic buffer between FL pipeline stages.

---
 rtl/fl_fifo_pkg.sv | 36 +++
 rtl/fl_fifo_mem.sv | 39 +++
 rtl/fl_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_fl_fifo.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fl_fifo_pkg.sv
// fl_fifo_pkg: shared constants, width helpers and FSM state type for the FrameLink FIFO.
//
// Contents:
//   clog2        - constant ceil(log2) helper usable in port and parameter declarations
//   rem_width    - width of the FrameLink REM field for a given data width
//   entry_width  - width of one stored FIFO entry {DATA, REM, SOF_N, EOF_N, SOP_N, EOP_N}
//   t_fl_fifo_state - output FSM states used when FL_FIFO_STORE_AND_FORWARD_EN is defined

package fl_fifo_pkg;

    // Number of control flags stored alongside each word: SOF_N, EOF_N, SOP_N, EOP_N.
    localparam int unsigned FL_FLAG_COUNT = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((result < 32) && ((64'd1 << result) < 64'(value))) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned rem_width(input int unsigned data_width);
        return clog2(data_width / 8);
    endfunction

    function automatic int unsigned entry_width(input int unsigned data_width);
        return data_width + rem_width(data_width) + FL_FLAG_COUNT;
    endfunction

    typedef enum logic {
        IDLE,
        SENDING
    } t_fl_fifo_state;

endpackage

// File: rtl/fl_fifo_mem.sv
// fl_fifo_mem: ITEMS x WIDTH register file backing the FrameLink FIFO.
//
// One synchronous write port, one asynchronous (combinational) read port so the
// FIFO head is visible in the same cycle the read pointer points at it. No reset:
// contents are only meaningful where the FIFO's pointers say an entry is valid.
//
// Ports:
//   clk_i    - clock, writes on the rising edge
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational from raddr_i)

module fl_fifo_mem
    import fl_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 71,
    parameter int unsigned ITEMS = 16
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [clog2(ITEMS)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [clog2(ITEMS)-1:0]   raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    logic [WIDTH-1:0] mem_q [ITEMS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fl_fifo.sv
// fl_fifo: synchronous first-word-fall-through FrameLink FIFO.
//
// Accepts FrameLink words on RX and re-emits them verbatim on TX. No protocol
// checking is done; every word is stored as {DATA, REM, SOF_N, EOF_N, SOP_N, EOP_N}.
//
// Build option:
//   FL_FIFO_STORE_AND_FORWARD_EN - when defined, TX only starts a frame once its
//   EOF word is stored (or the FIFO is full, for frames longer than ITEMS).
//   When undefined the FIFO is cut-through: TX_SRC_RDY_N = EMPTY.
//
// Ports:
//   CLK, RESET_N          - clock and synchronous active-low reset
//   RX_*                  - FrameLink input (sink side), RX_DST_RDY_N driven here
//   TX_*                  - FrameLink output (source side), TX_DST_RDY_N from downstream
//   STATUS                - number of stored words, 0..ITEMS
//   FRAMES                - number of stored words carrying EOF_N=0
//   EMPTY, FULL           - STATUS==0, STATUS==ITEMS

module fl_fifo
    import fl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ITEMS      = 16
) (
    input  logic                              CLK,
    input  logic                              RESET_N,

    input  logic [DATA_WIDTH-1:0]             RX_DATA,
    input  logic [rem_width(DATA_WIDTH)-1:0]  RX_REM,
    input  logic                              RX_SOF_N,
    input  logic                              RX_EOF_N,
    input  logic                              RX_SOP_N,
    input  logic                              RX_EOP_N,
    input  logic                              RX_SRC_RDY_N,
    output logic                              RX_DST_RDY_N,

    output logic [DATA_WIDTH-1:0]             TX_DATA,
    output logic [rem_width(DATA_WIDTH)-1:0]  TX_REM,
    output logic                              TX_SOF_N,
    output logic                              TX_EOF_N,
    output logic                              TX_SOP_N,
    output logic                              TX_EOP_N,
    output logic                              TX_SRC_RDY_N,
    input  logic                              TX_DST_RDY_N,

    output logic [clog2(ITEMS):0]             STATUS,
    output logic [clog2(ITEMS):0]             FRAMES,
    output logic                              EMPTY,
    output logic                              FULL
);

    localparam int unsigned REM_W   = rem_width(DATA_WIDTH);
    localparam int unsigned ENTRY_W = entry_width(DATA_WIDTH);
    localparam int unsigned PTR_W   = clog2(ITEMS);
    localparam int unsigned CNT_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ITEMS);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   status_q, status_d;
    logic [CNT_W-1:0]   frames_q, frames_d;

    logic               empty;
    logic               full;
    logic               rx_dst_rdy_n;
    logic               tx_src_rdy_n;
    logic               wr_en;
    logic               rd_en;
    logic               wr_eof;
    logic               rd_eof;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    logic [DATA_WIDTH-1:0] head_data;
    logic [REM_W-1:0]      head_rem;
    logic                  head_sof_n;
    logic                  head_eof_n;
    logic                  head_sop_n;
    logic                  head_eop_n;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign empty = (status_q == '0);
    assign full  = (status_q == FULL_CNT);

    // Gating on FULL alone (not on a concurrent read) forbids write-through when full.
    assign rx_dst_rdy_n = full | ~RESET_N;

    assign wr_en  = ~RX_SRC_RDY_N & ~rx_dst_rdy_n;
    assign rd_en  = ~tx_src_rdy_n & ~TX_DST_RDY_N;
    assign wr_eof = wr_en & ~RX_EOF_N;
    assign rd_eof = rd_en & ~head_eof_n;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign wr_entry = {RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N};

    fl_fifo_mem #(
        .WIDTH (ENTRY_W),
        .ITEMS (ITEMS)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign {head_data, head_rem, head_sof_n, head_eof_n, head_sop_n, head_eop_n} = rd_entry;

    // ------------------------------------------------------------------
    // Pointers and occupancy counters
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        status_d = status_q;
        frames_d = frames_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, rd_en})
            2'b10:   status_d = status_q + 1'b1;
            2'b01:   status_d = status_q - 1'b1;
            default: status_d = status_q;
        endcase

        unique case ({wr_eof, rd_eof})
            2'b10:   frames_d = frames_q + 1'b1;
            2'b01:   frames_d = frames_q - 1'b1;
            default: frames_d = frames_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            status_q <= '0;
            frames_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            status_q <= status_d;
            frames_q <= frames_d;
        end
    end

    // ------------------------------------------------------------------
    // TX valid generation
    // ------------------------------------------------------------------
`ifdef FL_FIFO_STORE_AND_FORWARD_EN
    t_fl_fifo_state state_q, state_d;
    logic           tx_src_rdy_n_q, tx_src_rdy_n_d;

    // The valid flag is registered from next-state values, so it equals the
    // IDLE/SENDING formula of the current cycle without a path from TX_DST_RDY_N.
    always_comb begin
        state_d = state_q;
        case (state_q)
            // A SOF word that is also EOF is a whole frame; stay in IDLE.
            IDLE:    if (rd_en && !head_sof_n && head_eof_n) state_d = SENDING;
            SENDING: if (rd_eof) state_d = IDLE;
        endcase

        if (state_d == SENDING) begin
            tx_src_rdy_n_d = (status_d == '0);
        end else begin
            // FULL fallback keeps frames longer than ITEMS from deadlocking.
            tx_src_rdy_n_d = !((frames_d != '0) || (status_d == FULL_CNT));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q        <= IDLE;
            tx_src_rdy_n_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            tx_src_rdy_n_q <= tx_src_rdy_n_d;
        end
    end

    assign tx_src_rdy_n = tx_src_rdy_n_q;
`else
    assign tx_src_rdy_n = empty;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign RX_DST_RDY_N = rx_dst_rdy_n;
    assign TX_SRC_RDY_N = tx_src_rdy_n;

    assign TX_DATA  = head_data;
    assign TX_REM   = head_rem;
    // Flags read as inactive while nothing is stored (memory has no reset).
    assign TX_SOF_N = head_sof_n | empty;
    assign TX_EOF_N = head_eof_n | empty;
    assign TX_SOP_N = head_sop_n | empty;
    assign TX_EOP_N = head_eop_n | empty;

    assign STATUS = status_q;
    assign FRAMES = frames_q;
    assign EMPTY  = empty;
    assign FULL   = full;

endmodule

// File: tb/tb_fl_fifo.sv
// tb_fl_fifo: directed self-checking bench for fl_fifo (DATA_WIDTH=64, ITEMS=16).
// Build option FL_FIFO_STORE_AND_FORWARD_EN selects the store-and-forward scenarios.

module tb_fl_fifo;

    localparam int unsigned DW = 64;
    localparam int unsigned RW = 3;
    localparam int unsigned EW = DW + RW + 4;

    typedef logic [EW-1:0] entry_t;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [DW-1:0] RX_DATA;
    logic [RW-1:0] RX_REM;
    logic          RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N, RX_DST_RDY_N;
    logic [DW-1:0] TX_DATA;
    logic [RW-1:0] TX_REM;
    logic          TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N, TX_DST_RDY_N;
    logic [4:0]    STATUS, FRAMES;
    logic          EMPTY, FULL;

    int     total = 0;
    int     bad = 0;
    int     tx_seen = 0;
    entry_t sb[$];
    entry_t mon_exp;

    always #5 CLK = ~CLK;

    fl_fifo #(
        .DATA_WIDTH (DW),
        .ITEMS      (16)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .RX_DATA      (RX_DATA),
        .RX_REM       (RX_REM),
        .RX_SOF_N     (RX_SOF_N),
        .RX_EOF_N     (RX_EOF_N),
        .RX_SOP_N     (RX_SOP_N),
        .RX_EOP_N     (RX_EOP_N),
        .RX_SRC_RDY_N (RX_SRC_RDY_N),
        .RX_DST_RDY_N (RX_DST_RDY_N),
        .TX_DATA      (TX_DATA),
        .TX_REM       (TX_REM),
        .TX_SOF_N     (TX_SOF_N),
        .TX_EOF_N     (TX_EOF_N),
        .TX_SOP_N     (TX_SOP_N),
        .TX_EOP_N     (TX_EOP_N),
        .TX_SRC_RDY_N (TX_SRC_RDY_N),
        .TX_DST_RDY_N (TX_DST_RDY_N),
        .STATUS       (STATUS),
        .FRAMES       (FRAMES),
        .EMPTY        (EMPTY),
        .FULL         (FULL)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic [2:0] rem, input logic sof_n,
                         input logic eof_n);
        RX_DATA      = d;
        RX_REM       = rem;
        RX_SOF_N     = sof_n;
        RX_EOF_N     = eof_n;
        RX_SOP_N     = sof_n;
        RX_EOP_N     = eof_n;
        RX_SRC_RDY_N = 1'b0;
    endtask

    task automatic rx_idle();
        RX_SRC_RDY_N = 1'b1;
        RX_SOF_N     = 1'b1;
        RX_EOF_N     = 1'b1;
        RX_SOP_N     = 1'b1;
        RX_EOP_N     = 1'b1;
        RX_DATA      = '0;
        RX_REM       = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        TX_DST_RDY_N = 1'b0;
        while (!EMPTY && n < 200) begin
            tick();
            n++;
        end
        check_val(tag, 64'(EMPTY), 64'd1);
    endtask

    // Ordering scoreboard: transfers are decided at the falling edge for the next rising edge.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            sb.delete();
        end else begin
            if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
                check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    check_val("tx_data", TX_DATA, mon_exp[EW-1:RW+4]);
                    check_val("tx_ctl", 64'({TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N}),
                              64'(mon_exp[RW+3:0]));
                    tx_seen++;
                end
            end
            if (!RX_SRC_RDY_N && !RX_DST_RDY_N) begin
                sb.push_back({RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N});
            end
        end
    end

    initial begin
        int base;
        int i;
        int cyc;
        logic acc;

        RESET_N      = 1'b0;
        TX_DST_RDY_N = 1'b1;
        rx_idle();

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_rx_dst_rdy", 64'(RX_DST_RDY_N), 64'd1);
        check_val("rst_status", 64'(STATUS), 64'd0);
        check_val("rst_frames", 64'(FRAMES), 64'd0);
        check_val("rst_empty_full", 64'({EMPTY, FULL}), 64'b10);
        check_val("rst_tx_src_rdy", 64'(TX_SRC_RDY_N), 64'd1);
        check_val("rst_tx_flags", 64'({TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N}), 64'hF);
        RESET_N = 1'b1;
        #1;
        check_val("rel_rx_dst_rdy", 64'(RX_DST_RDY_N), 64'd0);
        tick();

`ifndef FL_FIFO_STORE_AND_FORWARD_EN
        // ---------------- single 3-word frame, cut-through ----------------
        TX_DST_RDY_N = 1'b0;
        drive(64'h1111_0000_0000_0001, 3'd0, 1'b0, 1'b1);
        tick();
        check_val("f3_w0_valid", 64'(TX_SRC_RDY_N), 64'd0);
        check_val("f3_w0_data", TX_DATA, 64'h1111_0000_0000_0001);
        check_val("f3_w0_sof", 64'(TX_SOF_N), 64'd0);
        check_val("f3_w0_status", 64'(STATUS), 64'd1);
        check_val("f3_w0_frames", 64'(FRAMES), 64'd0);
        drive(64'h2222_0000_0000_0002, 3'd0, 1'b1, 1'b1);
        tick();
        check_val("f3_w1_data", TX_DATA, 64'h2222_0000_0000_0002);
        check_val("f3_w1_status", 64'(STATUS), 64'd1);
        drive(64'h3333_0000_0000_0003, 3'd5, 1'b1, 1'b0);
        tick();
        check_val("f3_w2_data", TX_DATA, 64'h3333_0000_0000_0003);
        check_val("f3_w2_eof_rem", 64'({TX_EOF_N, TX_REM}), 64'({1'b0, 3'd5}));
        check_val("f3_w2_frames", 64'(FRAMES), 64'd1);
        check_val("f3_w2_status", 64'(STATUS), 64'd1);
        rx_idle();
        tick();
        check_val("f3_end_status", 64'(STATUS), 64'd0);
        check_val("f3_end_frames", 64'(FRAMES), 64'd0);
        check_val("f3_end_valid", 64'(TX_SRC_RDY_N), 64'd1);
`endif

        // ---------------- fill to full, held 17th word, one read ----------------
        TX_DST_RDY_N = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(64'hA000_0000_0000_0000 | 64'(k), 3'(k), (k % 4) != 0, (k % 4) != 3);
            tick();
        end
        check_val("full_flag", 64'(FULL), 64'd1);
        check_val("full_rx_dst_rdy", 64'(RX_DST_RDY_N), 64'd1);
        check_val("full_status", 64'(STATUS), 64'd16);
        check_val("full_frames", 64'(FRAMES), 64'd4);
        check_val("full_head", TX_DATA, 64'hA000_0000_0000_0000);
        drive(64'hA000_0000_0000_0010, 3'd7, 1'b0, 1'b0);
        tick();
        check_val("full_hold_status", 64'(STATUS), 64'd16);
        check_val("full_hold_head", TX_DATA, 64'hA000_0000_0000_0000);
        TX_DST_RDY_N = 1'b0;
        tick();
        check_val("full_rd_status", 64'(STATUS), 64'd15);
        check_val("full_rd_rx_dst_rdy", 64'(RX_DST_RDY_N), 64'd0);
        check_val("full_rd_head", TX_DATA, 64'hA000_0000_0000_0001);
        TX_DST_RDY_N = 1'b1;
        tick();
        check_val("full_refill_status", 64'(STATUS), 64'd16);
        check_val("full_refill_frames", 64'(FRAMES), 64'd5);
        rx_idle();
        base = tx_seen;
        drain("full_drain_empty");
        check_val("full_drain_count", 64'(tx_seen - base), 64'd16);

        // ---------------- 40 words, random backpressure ----------------
        base = tx_seen;
        i    = 0;
        cyc  = 0;
        while (i < 40 && cyc < 1000) begin
            drive(64'hC000_0000_0000_0000 | 64'(i), 3'(i), (i % 5) != 0, (i % 5) != 4);
            TX_DST_RDY_N = 1'($urandom_range(0, 1));
            acc = !RX_DST_RDY_N;
            tick();
            check_val("rand_status_max", 64'(STATUS <= 5'd16), 64'd1);
            if (acc) i++;
            cyc++;
        end
        rx_idle();
        drain("rand_drain_empty");
        check_val("rand_count", 64'(tx_seen - base), 64'd40);

        // ---------------- reset mid-frame ----------------
        TX_DST_RDY_N = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(64'hD000_0000_0000_0000 | 64'(k), 3'd0, k != 0, 1'b1);
            tick();
        end
        check_val("mid_status", 64'(STATUS), 64'd5);
        rx_idle();
        RESET_N = 1'b0;
        #1;
        check_val("mid_rst_rx_dst_rdy", 64'(RX_DST_RDY_N), 64'd1);
        tick();
        RESET_N = 1'b1;
        #1;
        check_val("mid_status0", 64'(STATUS), 64'd0);
        check_val("mid_frames0", 64'(FRAMES), 64'd0);
        check_val("mid_tx_src_rdy", 64'(TX_SRC_RDY_N), 64'd1);
        check_val("mid_empty", 64'(EMPTY), 64'd1);
        check_val("mid_rx_dst_rdy", 64'(RX_DST_RDY_N), 64'd0);
        base = tx_seen;
        TX_DST_RDY_N = 1'b0;
        drive(64'hE000_0000_0000_0001, 3'd0, 1'b0, 1'b1);
        tick();
        drive(64'hE000_0000_0000_0002, 3'd2, 1'b1, 1'b0);
        tick();
        rx_idle();
        drain("mid_drain_empty");
        check_val("mid_fresh_count", 64'(tx_seen - base), 64'd2);

`ifdef FL_FIFO_STORE_AND_FORWARD_EN
        // ---------------- 4-word frame, one word per 3 cycles ----------------
        TX_DST_RDY_N = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(64'h5000_0000_0000_0000 | 64'(k), 3'd0, k != 0, 1'b1);
            tick();
            rx_idle();
            check_val("sf4_wait_a", 64'(TX_SRC_RDY_N), 64'd1);
            tick();
            check_val("sf4_wait_b", 64'(TX_SRC_RDY_N), 64'd1);
            tick();
            check_val("sf4_wait_c", 64'(TX_SRC_RDY_N), 64'd1);
        end
        drive(64'h5000_0000_0000_0003, 3'd4, 1'b1, 1'b0);
        tick();
        rx_idle();
        for (int k = 0; k < 4; k++) begin
            check_val("sf4_burst_valid", 64'(TX_SRC_RDY_N), 64'd0);
            check_val("sf4_burst_data", TX_DATA, 64'h5000_0000_0000_0000 | 64'(k));
            tick();
        end
        check_val("sf4_end_empty", 64'(EMPTY), 64'd1);
        check_val("sf4_end_valid", 64'(TX_SRC_RDY_N), 64'd1);

        // ---------------- 20-word frame, overflow fallback ----------------
        base = tx_seen;
        i    = 0;
        cyc  = 0;
        while (i < 20 && cyc < 500) begin
            drive(64'h6000_0000_0000_0000 | 64'(i), 3'd1, i != 0, i != 19);
            acc = !RX_DST_RDY_N;
            tick();
            if (acc) begin
                i++;
                if (i == 15) check_val("sf20_wait", 64'(TX_SRC_RDY_N), 64'd1);
                if (i == 16) begin
                    check_val("sf20_full", 64'(FULL), 64'd1);
                    check_val("sf20_start", 64'(TX_SRC_RDY_N), 64'd0);
                end
            end
            cyc++;
        end
        rx_idle();
        drain("sf20_drain_empty");
        check_val("sf20_count", 64'(tx_seen - base), 64'd20);
        // Back in IDLE: a lone SOF word without EOF must not be offered.
        drive(64'h7000_0000_0000_0000, 3'd0, 1'b0, 1'b1);
        tick();
        rx_idle();
        tick();
        check_val("sf20_idle_hold", 64'(TX_SRC_RDY_N), 64'd1);
        check_val("sf20_idle_status", 64'(STATUS), 64'd1);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
